keypad_fifo_ctrl: RTL
=====================

# keypad_fifo_ctrl

Sequencing controller for the 4-bit keypad code FIFO. Accepts one-cycle key strobes from the keypad encoder and writes them into the FIFO, dropping and counting keys that arrive while the FIFO is full. Drains the FIFO one code at a time through a read state machine and presents each code to the downstream consumer (display or serial output) on a valid/ready handshake. Sits between the encoder and the FIFO on the write side, and between the FIFO and the consumer on the read side.

## Interface

Parameters:
- DROP_W, 8, width of the saturating dropped-key counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe from the encoder: new key code available.
- key_code  in  4  encoded key, valid when key_valid=1.
- enable  in  1  1 = drain the FIFO; 0 = read FSM holds in IDLE (writes still accepted).
- wr_enable  out  1  FIFO write strobe.
- data  out  4  FIFO write data.
- full  in  1  FIFO full flag.
- empty  in  1  FIFO empty flag.
- rd_enable  out  1  FIFO read strobe.
- code  in  4  FIFO read data; updated on the clock edge that samples rd_enable=1.
- out_valid  out  1  out_code holds an undelivered key.
- out_code  out  4  key delivered to the consumer.
- out_ready  in  1  consumer accepts out_code when out_valid=1 and out_ready=1.
- overflow  out  1  sticky: at least one key dropped since last clear.
- drop_count  out  DROP_W  number of dropped keys, saturating at 2^DROP_W-1.
- clr_overflow  in  1  synchronous clear of overflow and drop_count.

## Operation

Write path (combinational strobe, no latency):
- wr_enable = key_valid & ~full; data = key_code.
- key_valid=1 & full=1 -> key dropped: overflow<=1, drop_count<=drop_count+1 (held at all-ones once saturated).
- clr_overflow=1 with no drop in the same cycle -> overflow<=0, drop_count<=0. If a drop and clr_overflow coincide -> overflow<=1, drop_count<=1 (the event wins over the clear).

Read FSM (Moore outputs), states:
- IDLE: rd_enable=0, out_valid=0. Go to READ if enable=1 & empty=0; otherwise stay.
- READ: rd_enable=1 for exactly one cycle. Always go to LOAD.
- LOAD: rd_enable=0. Capture code into out_code. Go to HOLD.
- HOLD: out_valid=1, out_code stable. If out_ready=1, go to IDLE; otherwise stay. enable=0 does not abort HOLD.
- Only one read is outstanding at any time. Because IDLE re-samples empty at least two cycles after the previous rd_enable, the FSM never reads an empty FIFO.
- Simultaneous FIFO write and read are legal. The FIFO handles them; the controller does not block either path.

Reset (reset=0, asynchronous) forces:
- State = IDLE; rd_enable=0, out_valid=0, out_code=0, overflow=0, drop_count=0.
- wr_enable follows key_valid & ~full combinationally even during reset.
- Reset during READ, LOAD or HOLD discards the word in flight. The FIFO shares the same reset.

## Timing

- Write latency: the key is written on the same edge as its key_valid strobe.
- Read latency: IDLE with empty=0 seen at cycle N -> rd_enable at N+1 -> LOAD at N+2 -> out_valid=1 at N+3.
- Minimum period per delivered key: 4 cycles (IDLE, READ, LOAD, HOLD with out_ready=1).
- Key written to an empty FIFO at cycle N: empty falls at N+1, rd_enable at N+2, out_valid at N+4.
- out_valid falls on the cycle after the out_ready handshake.
- overflow and drop_count update on the edge after the dropped strobe.

## Test plan

- Reset: hold reset=0 for 20 ns with key_valid toggling -> out_valid=0, rd_enable=0, overflow=0, drop_count=0, state IDLE. Release -> no rd_enable while empty=1.
- Single key: after reset, key_valid with key_code=4'h5, out_ready=1 -> wr_enable in the same cycle, rd_enable 2 cycles later, out_valid=1 with out_code=5 at +4 cycles for one cycle.
- Burst and order: write codes 0..15 back-to-back, enable=0, then enable=1 with out_ready=1 -> 16 handshakes in order 0..15, each 4 cycles apart; rd_enable never asserted while empty=1.
- Backpressure: out_ready=0 for 10 cycles with 3 codes queued -> out_code frozen at the first code, no rd_enable during HOLD. Release -> remaining 2 codes delivered in order.
- Overflow: fill the FIFO, send 3 more strobes -> wr_enable=0 for those strobes, drop_count=3, overflow=1. clr_overflow coincident with a 4th drop -> drop_count=1, overflow=1. Saturation test with DROP_W=2 -> count stops at 3.
- Reset mid-read: assert reset during LOAD -> out_valid stays 0, state IDLE. After release, normal operation resumes on the next write.

Source files
------------

// File: rtl/keypad_fifo_ctrl.sv
// Keypad code FIFO controller: encoder -> FIFO write path with drop counting,
// FIFO -> consumer read FSM with valid/ready delivery.
//   Write side : key_valid/key_code in, wr_enable/data to FIFO, full from FIFO.
//   Read side  : empty/code from FIFO, rd_enable to FIFO, enable gates draining.
//   Consumer   : out_valid/out_code out, out_ready in.
//   Status     : overflow (sticky), drop_count (saturating), clr_overflow in.
module keypad_fifo_ctrl #(
    parameter int DROP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              enable,
    output logic              wr_enable,
    output logic [3:0]        data,
    input  logic              full,
    input  logic              empty,
    output logic              rd_enable,
    input  logic [3:0]        code,
    output logic              out_valid,
    output logic [3:0]        out_code,
    input  logic              out_ready,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clr_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD,
        HOLD
    } state_t;

    state_t state;
    logic   drop;

    // Write path is purely combinational so the key lands on its own edge.
    assign wr_enable = key_valid & ~full;
    assign data      = key_code;
    assign drop      = key_valid & full;

    // Read FSM with registered Moore outputs; rd_enable is set on entry to
    // READ so the strobe lines up with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_enable <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= 4'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && !empty) begin
                        state     <= READ;
                        rd_enable <= 1'b1;
                    end
                end
                READ: begin
                    state     <= LOAD;
                    rd_enable <= 1'b0;
                end
                LOAD: begin
                    // FIFO read data became valid on the edge ending READ.
                    out_code  <= code;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rd_enable <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_count <= DROP_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule
